// File: rtl/rvm_ctrl_seq_if.sv
// rtl/rvm_ctrl_seq_if.sv - instruction/data memory req/gnt handshake bundle
interface rvm_ctrl_seq_if;
   logic imem_req;
   logic imem_gnt;
   logic imem_err;
   logic dmem_req;
   logic dmem_wen;
   logic dmem_gnt;
   logic dmem_err;

   modport master (
      output imem_req, input imem_gnt, input imem_err,
      output dmem_req, output dmem_wen, input dmem_gnt, input dmem_err
   );

   modport slave (
      input imem_req, output imem_gnt, output imem_err,
      input dmem_req, input dmem_wen, output dmem_gnt, output dmem_err
   );
endinterface

// File: rtl/rvm_ctrl_seq.sv
// rtl/rvm_ctrl_seq.sv - multi-cycle control sequencer with req/gnt timeouts and traps
module rvm_ctrl_seq #(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             resetn,
   rvm_ctrl_seq_if.master   mem,
   input  logic             dec_illegal,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_writes_rd,
   input  logic             irq,
   output logic             ctl_ir_wen,
   output logic             ctl_rf_wen,
   output logic             ctl_pc_wen,
   output logic             ctl_trap,
   output logic [4:0]       ctl_trap_cause,
   output logic [2:0]       ctl_state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);
   localparam logic [2:0] S_FETCH     = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_EXECUTE   = 3'd2;
   localparam logic [2:0] S_MEMORY    = 3'd3;
   localparam logic [2:0] S_WRITEBACK = 3'd4;
   localparam logic [2:0] S_TRAP      = 3'd5;

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [4:0]        cause;
   logic [4:0]        cause_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              store_q;
   logic              timeout_hit;
   logic              req_wait;

   // The TIMEOUT-th ungranted cycle is the one where the counter already holds TIMEOUT-1.
   assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign req_wait    = (state == S_FETCH  && !mem.imem_gnt) ||
                        (state == S_MEMORY && !mem.dmem_gnt);

   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      case (state)
         S_FETCH: begin
            if (mem.imem_gnt) begin
               if (mem.imem_err) begin
                  state_nxt = S_TRAP;
                  cause_nxt = 5'd1;
               end else begin
                  state_nxt = S_DECODE;
               end
            end else if (timeout_hit) begin
               state_nxt = S_TRAP;
               cause_nxt = 5'd1;
            end
         end
         S_DECODE: begin
            if (irq) begin
               state_nxt = S_TRAP;
               cause_nxt = 5'h1B;
            end else if (dec_illegal) begin
               state_nxt = S_TRAP;
               cause_nxt = 5'd2;
            end else begin
               state_nxt = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            state_nxt = (dec_is_load || dec_is_store) ? S_MEMORY : S_WRITEBACK;
         end
         S_MEMORY: begin
            if (mem.dmem_gnt && !mem.dmem_err) begin
               state_nxt = S_WRITEBACK;
            end else if (mem.dmem_gnt || timeout_hit) begin
               state_nxt = S_TRAP;
               cause_nxt = store_q ? 5'd7 : 5'd5;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_FETCH;
         cause       <= '0;
         wait_cnt    <= '0;
         store_q     <= 1'b0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cause     <= cause_nxt;
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         // Any state change clears the counter, which covers entry to FETCH and MEMORY.
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (req_wait) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (state == S_EXECUTE) begin
            store_q <= dec_is_store;
         end
         if (state == S_WRITEBACK) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
         end
      end
   end

   // resetn gates the decoded outputs so requests drop the instant reset asserts.
   assign mem.imem_req   = resetn && (state == S_FETCH);
   assign mem.dmem_req   = resetn && (state == S_MEMORY);
   assign mem.dmem_wen   = resetn && (state == S_MEMORY) && store_q;
   assign ctl_ir_wen     = resetn && (state == S_FETCH) && mem.imem_gnt && !mem.imem_err;
   assign ctl_rf_wen     = resetn && (state == S_WRITEBACK) && dec_writes_rd && !dec_is_store;
   assign ctl_pc_wen     = resetn && ((state == S_WRITEBACK) || (state == S_TRAP));
   assign ctl_trap       = resetn && (state == S_TRAP);
   assign ctl_trap_cause = cause;
   assign ctl_state      = state;
endmodule

// File: tb/tb_rvm_ctrl_seq.sv
// tb/tb_rvm_ctrl_seq.sv - randomized instruction-level check of rvm_ctrl_seq
module tb_rvm_ctrl_seq;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        dec_illegal = 1'b0, dec_is_load = 1'b0, dec_is_store = 1'b0;
   logic        dec_writes_rd = 1'b0, irq = 1'b0;
   logic        ctl_ir_wen, ctl_rf_wen, ctl_pc_wen, ctl_trap;
   logic [4:0]  ctl_trap_cause;
   logic [2:0]  ctl_state;
   logic [63:0] cycle_cnt, instret_cnt;

   rvm_ctrl_seq_if mif ();

   rvm_ctrl_seq #(.CNT_W(64), .TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn), .mem(mif.master),
      .dec_illegal(dec_illegal), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_writes_rd(dec_writes_rd), .irq(irq),
      .ctl_ir_wen(ctl_ir_wen), .ctl_rf_wen(ctl_rf_wen), .ctl_pc_wen(ctl_pc_wen),
      .ctl_trap(ctl_trap), .ctl_trap_cause(ctl_trap_cause), .ctl_state(ctl_state),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // One expected cycle: inputs to apply plus outputs the architecture dictates.
   typedef struct {
      logic        ig, ie, dg, de, irq, ill, ld, st, wrd;
      logic [2:0]  state;
      logic [6:0]  ctl;
      logic [4:0]  cause;
      longint unsigned instret;
   } cyc_t;

   cyc_t            q[$];
   int              n_tests = 0;
   int              n_fail  = 0;
   longint unsigned m_cyc = 0, m_instret = 0;
   logic [4:0]      m_cause = 5'd0;
   logic            c_irq, c_ill, c_ld, c_st, c_wrd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ctl_vec();
      return {mif.imem_req, ctl_ir_wen, mif.dmem_req, mif.dmem_wen,
              ctl_rf_wen, ctl_pc_wen, ctl_trap};
   endfunction

   task automatic add(input logic [2:0] s, input logic ig, input logic ie,
                      input logic dg, input logic de, input logic [6:0] c);
      cyc_t r;
      r.ig = ig; r.ie = ie; r.dg = dg; r.de = de;
      r.irq = c_irq; r.ill = c_ill; r.ld = c_ld; r.st = c_st; r.wrd = c_wrd;
      r.state = s; r.ctl = c; r.cause = m_cause; r.instret = m_instret;
      q.push_back(r);
   endtask

   task automatic trap(input logic [4:0] c);
      m_cause = c;
      add(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000011);
   endtask

   // kind: 0 = ALU, 1 = load, 2 = store. fw/dw = wait states before gnt.
   task automatic plan(input int fw, input bit ferr, input bit irq_i, input bit ill,
                       input int kind, input bit wrd, input int dw, input bit derr);
      bit got;
      int n;
      c_irq = irq_i; c_ill = ill; c_ld = (kind == 1); c_st = (kind == 2); c_wrd = wrd;
      got = (fw < TO);
      n   = got ? fw + 1 : TO;
      for (int k = 0; k < n; k++) begin
         bit g;
         g = got && (k == n - 1);
         add(3'd0, g, g & ferr, 1'b0, 1'b0, {1'b1, g & ~ferr, 5'b0});
      end
      if (!got || ferr) begin trap(5'd1); return; end
      add(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0);
      if (irq_i) begin trap(5'h1B); return; end
      if (ill) begin trap(5'd2); return; end
      add(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0);
      if (kind != 0) begin
         got = (dw < TO);
         n   = got ? dw + 1 : TO;
         for (int k = 0; k < n; k++) begin
            bit g;
            g = got && (k == n - 1);
            add(3'd3, 1'b0, 1'b0, g, g & derr, {2'b0, 1'b1, kind == 2, 3'b0});
         end
         if (!got || derr) begin trap(kind == 2 ? 5'd7 : 5'd5); return; end
      end
      add(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0, wrd && kind != 2, 1'b1, 1'b0});
      m_instret++;
   endtask

   task automatic drive(input cyc_t r);
      mif.imem_gnt = r.ig; mif.imem_err = r.ie; mif.dmem_gnt = r.dg; mif.dmem_err = r.de;
      irq = r.irq; dec_illegal = r.ill; dec_is_load = r.ld; dec_is_store = r.st;
      dec_writes_rd = r.wrd;
   endtask

   // Called at a negedge; leaves at a negedge.
   task automatic run(input int limit);
      int left;
      left = limit;
      while (q.size() > 0 && left > 0) begin
         cyc_t r;
         r = q.pop_front();
         drive(r);
         #1;
         chk("state", 64'(ctl_state), 64'(r.state));
         chk("ctl", 64'(ctl_vec()), 64'(r.ctl));
         chk("cause", 64'(ctl_trap_cause), 64'(r.cause));
         chk("instret", instret_cnt, r.instret);
         chk("cycle", cycle_cnt, m_cyc);
         @(posedge clk);
         @(negedge clk);
         m_cyc++;
         left--;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      mif.imem_gnt = 1'b1; mif.imem_err = 1'b0; mif.dmem_gnt = 1'b1; mif.dmem_err = 1'b1;
      irq = 1'b1; dec_illegal = 1'b1; dec_is_load = 1'b1; dec_is_store = 1'b1;
      dec_writes_rd = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_ctl", 64'(ctl_vec()), 64'd0);
      chk("rst_state", 64'(ctl_state), 64'd0);
      chk("rst_cause", 64'(ctl_trap_cause), 64'd0);
      chk("rst_cycle", cycle_cnt, 64'd0);
      chk("rst_instret", instret_cnt, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      m_cyc = 0; m_instret = 0; m_cause = 5'd0;
   endtask

   function automatic int rand_wait();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) return int'($urandom_range(0, 3));
      if (sel == 5) return TO - 1;
      if (sel == 6) return TO;
      return int'($urandom_range(0, TO + 2));
   endfunction

   initial begin
      mif.imem_gnt = 1'b0; mif.imem_err = 1'b0; mif.dmem_gnt = 1'b0; mif.dmem_err = 1'b0;
      @(negedge clk);
      do_reset();

      plan(0, 0, 0, 0, 0, 1, 0, 0);        // ALU, 4 cycles
      plan(0, 0, 0, 0, 1, 1, 3, 0);        // load with 3 data waits
      plan(TO + 5, 0, 0, 0, 0, 1, 0, 0);   // fetch timeout
      plan(0, 0, 0, 1, 0, 1, 0, 0);        // illegal
      plan(0, 0, 0, 0, 2, 1, 0, 1);        // store bus error
      plan(0, 0, 1, 1, 1, 1, 0, 0);        // irq beats illegal
      plan(TO - 1, 0, 0, 0, 1, 1, TO - 1, 0); // gnt on the timeout cycle
      plan(0, 0, 0, 0, 2, 0, TO + 3, 0);   // store timeout
      plan(2, 1, 0, 0, 0, 1, 0, 0);        // fetch bus error
      run(100000);

      for (int i = 0; i < 250; i++) begin
         plan(rand_wait(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), 1'($urandom),
              rand_wait(), ($urandom_range(0, 7) == 0));
         run(100000);
      end

      // Reset while a load is waiting on dmem.
      plan(0, 0, 0, 0, 1, 1, 10, 0);
      run(4);
      mif.dmem_gnt = 1'b0; mif.dmem_err = 1'b0;
      #1;
      chk("mid_dmem_req", 64'(mif.dmem_req), 64'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_ctl", 64'(ctl_vec()), 64'd0);
      chk("mid_rst_state", 64'(ctl_state), 64'd0);
      chk("mid_rst_cycle", cycle_cnt, 64'd0);
      chk("mid_rst_instret", instret_cnt, 64'd0);
      q.delete();
      do_reset();
      plan(1, 0, 0, 0, 0, 1, 0, 0);
      run(100000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
